mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage initiator for the byte-addressed data memory.
- Turns pipeline load/store requests into a DMEM_READ/DMEM_WRITE request with a held FUNCT3, address and data.
- Holds the pipeline with STALL for the programmed access time, then returns the sign/zero-extended load result.
- Sits between the EX/MEM pipeline register and the data memory; its DMEM_* ports connect directly to that memory's READ/WRITE/FUNCT3/ADDRESS/WRITEDATA/READDATA/BUSYWAIT.

Parameters:
- MEM_CYCLES, 5, number of clock cycles a request is held asserted before read data is sampled or a write is considered complete (memory access time / clock period, rounded up); legal range 1..15.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-low reset (RESET=0 resets at a rising CLK edge).
- MEM_READ  in  1  load request from the pipeline; held stable while STALL=1.
- MEM_WRITE  in  1  store request from the pipeline; held stable while STALL=1.
- FUNCT3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- ADDRESS  in  32  effective address (ALU result).
- WRITEDATA  in  32  store data (rs2 value).
- LOAD_DATA  out  32  extended load result; valid in DONE.
- STALL  out  1  freeze IF..MEM while high.
- ACCESS_FAULT  out  1  one-cycle pulse for a misaligned, illegal-funct3 or read+write request.
- DMEM_READ  out  1  memory read request.
- DMEM_WRITE  out  1  memory write request.
- DMEM_FUNCT3  out  3  registered copy of FUNCT3.
- DMEM_ADDRESS  out  32  registered address.
- DMEM_WRITEDATA  out  32  registered store data.
- DMEM_READDATA  in  32  [31:24]=byte@addr, [23:16]=@addr+1, [15:8]=@addr+2, [7:0]=@addr+3.
- DMEM_BUSYWAIT  in  1  memory busy flag; monitored only, see Behaviour.

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset (RESET=0 at a CLK edge) sets:
  - state IDLE, counter 0;
  - DMEM_READ=0, DMEM_WRITE=0, DMEM_FUNCT3=0, DMEM_ADDRESS=0, DMEM_WRITEDATA=0;
  - LOAD_DATA=0, ACCESS_FAULT=0.
- Reset mid-access aborts immediately: requests drop at that edge, no LOAD_DATA update. STALL is 0 during reset.
- IDLE, request valid (exactly one of MEM_READ/MEM_WRITE, legal FUNCT3, aligned):
  - register DMEM_* fields, assert the matching DMEM_READ or DMEM_WRITE, counter := MEM_CYCLES-1, go ACCESS.
  - Legal FUNCT3 for stores is 000/001/010 only.
  - Aligned means: halfword ADDRESS[0]=0; word ADDRESS[1:0]=00.
- IDLE, invalid request:
  - no memory request issued; ACCESS_FAULT=1 for one cycle; stay IDLE; STALL=0.
  - Invalid covers misaligned, illegal FUNCT3, or both MEM_READ and MEM_WRITE high.
- IDLE, no request: all DMEM requests 0, STALL=0.
- STALL (combinational) = state==ACCESS, or (state==IDLE and a valid request present).
  - First stall cycle is therefore the request cycle itself.
- ACCESS:
  - requests held constant; counter decrements each cycle.
  - When counter==0: drop DMEM_READ/DMEM_WRITE; for a load, capture and extend read data into LOAD_DATA; go DONE.
  - Requests are high exactly MEM_CYCLES cycles.
- Load assembly (little-endian): raw = {DMEM_READDATA[7:0], [15:8], [23:16], [31:24]}.
  - LW = raw.
  - LH = sign-extend raw[15:0]; LHU = zero-extend raw[15:0].
  - LB = sign-extend raw[7:0]; LBU = zero-extend raw[7:0].
- Stores: LOAD_DATA unchanged.
- DONE: STALL=0 for one cycle (pipeline advances), LOAD_DATA stable; next state IDLE unconditionally.
  - Back-to-back accesses are therefore separated by one non-stalled cycle.
- Total load latency: MEM_CYCLES+1 cycles from request to LOAD_DATA valid in DONE.
- DMEM_BUSYWAIT:
  - Expected 1 whenever a request is high.
  - If it is 0 while DMEM_READ|DMEM_WRITE=1 in ACCESS, raise ACCESS_FAULT for that cycle (protocol error); the access still completes on the counter.
- Address arithmetic: no wrap logic; address forwarded unmodified.

Test Plan:
1. Reset: RESET=0 for 2 edges during an active LW -> DMEM_READ=0 next edge, STALL=0, LOAD_DATA=0, state IDLE.
2. SW then LW at 0x10, data 0xDEADBEEF, MEM_CYCLES=5:
   - DMEM_WRITE high exactly 5 cycles, STALL high 6 cycles;
   - memory bytes 0x10..0x13 = EF,BE,AD,DE;
   - subsequent LW returns LOAD_DATA=0xDEADBEEF in DONE, 6 cycles after request.
3. Memory bytes 0x20..0x23 = 0x80,0xFF,0x12,0x34:
   - LB 0x20 -> 0xFFFFFF80; LBU 0x20 -> 0x00000080;
   - LH 0x20 -> 0xFFFFFF80 (raw 0xFF80); LHU 0x20 -> 0x0000FF80.
4. Faults, each with no DMEM request issued and STALL=0:
   - LW at 0x22 -> ACCESS_FAULT pulse;
   - SH at 0x21 -> ACCESS_FAULT;
   - MEM_READ=MEM_WRITE=1 -> ACCESS_FAULT;
   - FUNCT3=011 load -> ACCESS_FAULT.
5. SB 0x5A to 0x31 over existing word 0x11223344 at 0x30 -> only byte 0x31 becomes 0x5A; LW 0x30 -> 0x11225A44.
6. Back-to-back LW requests held continuously -> exactly one STALL=0 (DONE) cycle between the two access windows; second LOAD_DATA correct; DMEM_BUSYWAIT forced 0 mid-access -> ACCESS_FAULT pulse, access still completes.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: converts pipeline load/store requests into a timed
// data-memory access, stalling the pipeline until the access completes.
module mem_access_unit #(
  parameter int MEM_CYCLES = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITEDATA,
  output logic [31:0] LOAD_DATA,
  output logic        STALL,
  output logic        ACCESS_FAULT,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  output logic [2:0]  DMEM_FUNCT3,
  output logic [31:0] DMEM_ADDRESS,
  output logic [31:0] DMEM_WRITEDATA,
  input  logic [31:0] DMEM_READDATA,
  input  logic        DMEM_BUSYWAIT
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(MEM_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  counter;
  logic        f3_legal;
  logic        aligned;
  logic        req_any;
  logic        req_valid;
  logic        req_invalid;
  logic [31:0] raw;
  logic [31:0] load_ext;

  // Unsigned load sizes are legal only for reads; stores accept SB/SH/SW.
  always_comb begin
    f3_legal = 1'b0;
    aligned  = 1'b0;
    case (FUNCT3)
      3'b000: begin f3_legal = 1'b1;     aligned = 1'b1;                  end
      3'b001: begin f3_legal = 1'b1;     aligned = ~ADDRESS[0];           end
      3'b010: begin f3_legal = 1'b1;     aligned = (ADDRESS[1:0] == 2'b00); end
      3'b100: begin f3_legal = MEM_READ; aligned = 1'b1;                  end
      3'b101: begin f3_legal = MEM_READ; aligned = ~ADDRESS[0];           end
      default: begin f3_legal = 1'b0;    aligned = 1'b0;                  end
    endcase
  end

  assign req_any     = MEM_READ | MEM_WRITE;
  assign req_valid   = (MEM_READ ^ MEM_WRITE) & f3_legal & aligned;
  assign req_invalid = req_any & ~req_valid;

  assign STALL = RESET & ((state == ACCESS) | ((state == IDLE) & req_valid));

  // Memory returns the byte at the address in the top lane; reverse to little-endian.
  assign raw = {DMEM_READDATA[7:0], DMEM_READDATA[15:8],
                DMEM_READDATA[23:16], DMEM_READDATA[31:24]};

  always_comb begin
    load_ext = raw;
    case (DMEM_FUNCT3)
      3'b000:  load_ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  load_ext = {{16{raw[15]}}, raw[15:0]};
      3'b100:  load_ext = {24'h000000, raw[7:0]};
      3'b101:  load_ext = {16'h0000, raw[15:0]};
      default: load_ext = raw;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state          <= IDLE;
      counter        <= 4'd0;
      DMEM_READ      <= 1'b0;
      DMEM_WRITE     <= 1'b0;
      DMEM_FUNCT3    <= 3'b000;
      DMEM_ADDRESS   <= 32'h0;
      DMEM_WRITEDATA <= 32'h0;
      LOAD_DATA      <= 32'h0;
      ACCESS_FAULT   <= 1'b0;
    end else begin
      ACCESS_FAULT <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            DMEM_READ      <= MEM_READ;
            DMEM_WRITE     <= MEM_WRITE;
            DMEM_FUNCT3    <= FUNCT3;
            DMEM_ADDRESS   <= ADDRESS;
            DMEM_WRITEDATA <= WRITEDATA;
            counter        <= CNT_INIT;
            state          <= ACCESS;
          end else if (req_invalid) begin
            ACCESS_FAULT <= 1'b1;
          end
        end
        ACCESS: begin
          // A memory that stops asserting busy mid-request breaks the protocol.
          if ((DMEM_READ | DMEM_WRITE) & ~DMEM_BUSYWAIT) begin
            ACCESS_FAULT <= 1'b1;
          end
          if (counter == 4'd0) begin
            DMEM_READ  <= 1'b0;
            DMEM_WRITE <= 1'b0;
            if (DMEM_READ) begin
              LOAD_DATA <= load_ext;
            end
            state <= DONE;
          end else begin
            counter <= counter - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a byte-array
// memory model attached to the DMEM port.
module tb_mem_access_unit;

  logic        clk;
  logic        reset_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] load_data;
  logic        stall;
  logic        access_fault;
  logic        dmem_read;
  logic        dmem_write;
  logic [2:0]  dmem_funct3;
  logic [31:0] dmem_address;
  logic [31:0] dmem_writedata;
  logic [31:0] dmem_readdata;
  logic        dmem_busywait;
  logic        force_busy_low;

  logic [7:0]  mem [0:255] = '{default: 8'h00};
  logic [7:0]  ma;

  int          checks = 0;
  int          errors = 0;
  int          stall_n;
  int          req_n;
  logic [31:0] ld_seen;
  logic [31:0] seen_addr;
  logic [31:0] seen_wdata;
  logic [2:0]  seen_f3;
  logic [13:0] stall_trace;
  logic [13:0] req_trace;
  logic [13:0] fault_trace;
  logic [31:0] ld_first;
  logic [31:0] ld_second;

  mem_access_unit #(.MEM_CYCLES(5)) dut (
    .CLK(clk),
    .RESET(reset_n),
    .MEM_READ(mem_read),
    .MEM_WRITE(mem_write),
    .FUNCT3(funct3),
    .ADDRESS(address),
    .WRITEDATA(writedata),
    .LOAD_DATA(load_data),
    .STALL(stall),
    .ACCESS_FAULT(access_fault),
    .DMEM_READ(dmem_read),
    .DMEM_WRITE(dmem_write),
    .DMEM_FUNCT3(dmem_funct3),
    .DMEM_ADDRESS(dmem_address),
    .DMEM_WRITEDATA(dmem_writedata),
    .DMEM_READDATA(dmem_readdata),
    .DMEM_BUSYWAIT(dmem_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ma            = dmem_address[7:0];
  assign dmem_readdata = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};
  assign dmem_busywait = (dmem_read | dmem_write) & ~force_busy_low;

  // Little-endian byte memory; repeated writes over the request window are idempotent.
  always @(posedge clk) begin
    if (dmem_write) begin
      case (dmem_funct3)
        3'b000: mem[ma] <= dmem_writedata[7:0];
        3'b001: begin
          mem[ma]         <= dmem_writedata[7:0];
          mem[ma + 8'd1]  <= dmem_writedata[15:8];
        end
        default: begin
          mem[ma]         <= dmem_writedata[7:0];
          mem[ma + 8'd1]  <= dmem_writedata[15:8];
          mem[ma + 8'd2]  <= dmem_writedata[23:16];
          mem[ma + 8'd3]  <= dmem_writedata[31:24];
        end
      endcase
    end
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    address   = addr;
    writedata = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request, count stalled and requesting cycles, then release it.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    applyStimulus(rd, wr, f3, addr, wdata);
    stall_n = 0;
    req_n   = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dmem_read | dmem_write) begin
        if (req_n == 0) begin
          seen_addr  = dmem_address;
          seen_wdata = dmem_writedata;
          seen_f3    = dmem_funct3;
        end
        req_n++;
      end
      if (!stall) break;
      stall_n++;
      @(posedge clk);
      #1;
    end
    ld_seen = load_data;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic check_fault(input string tag);
    checkOutput({tag, "_stall"}, 32'(stall_n), 32'd0);
    checkOutput({tag, "_req"}, 32'(req_n), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, {31'd0, access_fault}, 32'd1);
    checkOutput({tag, "_noreq"}, {30'd0, dmem_read, dmem_write}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_pulse_end"}, {31'd0, access_fault}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    force_busy_low = 1'b0;
    reset_n        = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_req", {30'd0, dmem_read, dmem_write}, 32'd0);
    checkOutput("rst_funct3", {29'd0, dmem_funct3}, 32'd0);
    checkOutput("rst_addr", dmem_address, 32'd0);
    checkOutput("rst_wdata", dmem_writedata, 32'd0);
    checkOutput("rst_load", load_data, 32'd0);
    checkOutput("rst_fault", {31'd0, access_fault}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // SW then LW of 0xDEADBEEF at 0x10
    do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    checkOutput("sw_stall_cycles", 32'(stall_n), 32'd6);
    checkOutput("sw_req_cycles", 32'(req_n), 32'd5);
    checkOutput("sw_addr", seen_addr, 32'h10);
    checkOutput("sw_wdata", seen_wdata, 32'hDEADBEEF);
    checkOutput("sw_load_unchanged", ld_seen, 32'h0);
    checkOutput("sw_bytes", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hEFBEADDE);
    do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    checkOutput("lw_stall_cycles", 32'(stall_n), 32'd6);
    checkOutput("lw_req_cycles", 32'(req_n), 32'd5);
    checkOutput("lw_data", ld_seen, 32'hDEADBEEF);

    // Sign/zero extension on bytes 80,FF,12,34 at 0x20
    do_access(1'b0, 1'b1, 3'b010, 32'h20, 32'h3412FF80);
    do_access(1'b1, 1'b0, 3'b000, 32'h20, 32'h0);
    checkOutput("lb_20", ld_seen, 32'hFFFFFF80);
    do_access(1'b1, 1'b0, 3'b100, 32'h20, 32'h0);
    checkOutput("lbu_20", ld_seen, 32'h00000080);
    do_access(1'b1, 1'b0, 3'b001, 32'h20, 32'h0);
    checkOutput("lh_20", ld_seen, 32'hFFFFFF80);
    do_access(1'b1, 1'b0, 3'b101, 32'h20, 32'h0);
    checkOutput("lhu_20", ld_seen, 32'h0000FF80);
    do_access(1'b1, 1'b0, 3'b100, 32'h21, 32'h0);
    checkOutput("lbu_21", ld_seen, 32'h000000FF);
    do_access(1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
    checkOutput("lh_22", ld_seen, 32'h00003412);
    do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    checkOutput("lw_20", ld_seen, 32'h3412FF80);

    // Rejected requests
    do_access(1'b1, 1'b0, 3'b010, 32'h22, 32'h0);
    check_fault("lw_misaligned");
    do_access(1'b0, 1'b1, 3'b001, 32'h21, 32'h1234);
    check_fault("sh_misaligned");
    do_access(1'b1, 1'b1, 3'b010, 32'h40, 32'h0);
    check_fault("rd_and_wr");
    do_access(1'b1, 1'b0, 3'b011, 32'h40, 32'h0);
    check_fault("f3_011_load");
    do_access(1'b0, 1'b1, 3'b100, 32'h40, 32'h0);
    check_fault("f3_100_store");
    checkOutput("fault_load_kept", load_data, 32'h3412FF80);

    // SB into the middle of a word
    do_access(1'b0, 1'b1, 3'b010, 32'h30, 32'h11223344);
    do_access(1'b0, 1'b1, 3'b000, 32'h31, 32'h0000005A);
    checkOutput("sb_funct3", {29'd0, seen_f3}, 32'd0);
    checkOutput("sb_addr", seen_addr, 32'h31);
    do_access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    checkOutput("sb_merge", ld_seen, 32'h11225A44);

    // Back-to-back loads held continuously, with a busy dropout mid-access
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    stall_trace = '0;
    req_trace   = '0;
    fault_trace = '0;
    ld_first    = '0;
    ld_second   = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      stall_trace[c] = stall;
      req_trace[c]   = dmem_read | dmem_write;
      fault_trace[c] = access_fault;
      if (c == 6) begin
        ld_first = load_data;
        address  = 32'h30;
      end
      if (c == 13) ld_second = load_data;
      @(posedge clk);
      #1;
      force_busy_low = (c == 2);
    end
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("b2b_stall_trace", {18'd0, stall_trace}, 32'h00001FBF);
    checkOutput("b2b_req_trace", {18'd0, req_trace}, 32'h00001F3E);
    checkOutput("b2b_fault_trace", {18'd0, fault_trace}, 32'h00000010);
    checkOutput("b2b_first", ld_first, 32'hDEADBEEF);
    checkOutput("b2b_second", ld_second, 32'h11225A44);

    // Reset in the middle of an active LW
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_rst_req", {31'd0, dmem_read}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("in_rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("mid_rst_req", {31'd0, dmem_read}, 32'd0);
    checkOutput("mid_rst_load", load_data, 32'd0);
    checkOutput("mid_rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("post_rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("post_rst_req", {31'd0, dmem_read}, 32'd0);
    @(posedge clk);
    #1;
    do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    checkOutput("post_rst_lw_stall", 32'(stall_n), 32'd6);
    checkOutput("post_rst_lw_data", ld_seen, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
